// File: rtl/block_transfer_sequencer_pkg.sv
// Shared constants and state encoding for the LDM/STM block transfer sequencer.
package block_transfer_sequencer_pkg;

  localparam int unsigned NREGS      = 16;
  localparam int unsigned RADDR_W    = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XFER   = 3'd1,
    S_WRITE  = 3'd2,
    S_WBACK  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/block_transfer_sequencer_lsb.sv
// Priority encoder: index of the lowest set bit of a 16-bit mask, plus a non-empty flag.
module lowest_set_bit16 (
  input  logic [15:0] i_mask,
  output logic [3:0]  o_index,
  output logic        o_valid
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    o_index = '0;
    o_valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_index = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: walks a register list low to high, issuing one memory word access per
// set bit, driving the register file write port for loads and the optional base writeback.
module block_transfer_sequencer
  import block_transfer_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_is_load,
  input  logic               i_up,
  input  logic               i_wb,
  input  logic [NREGS-1:0]   i_reg_list,
  input  logic [RADDR_W-1:0] i_base_reg,
  input  logic [DATA_W-1:0]  i_base_addr,
  output logic [RADDR_W-1:0] o_rf_a,
  input  logic [DATA_W-1:0]  i_rf_pa,
  output logic [RADDR_W-1:0] o_rf_c,
  output logic [DATA_W-1:0]  o_rf_pc,
  output logic               o_rf_enable,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [DATA_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  input  logic               i_mem_done,
  output logic               o_busy,
  output logic               o_done
);

  state_e               r_state;
  logic [NREGS-1:0]     r_mask;
  logic [RADDR_W-1:0]   r_cur_reg;
  logic [DATA_W-1:0]    r_cur_addr;
  logic [DATA_W-1:0]    r_final_base;
  logic                 r_is_load;
  logic                 r_wb;
  logic [RADDR_W-1:0]   r_base_reg;
  logic                 r_base_in_list;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic                 r_rf_enable;
  logic [RADDR_W-1:0]   r_rf_c;
  logic [DATA_W-1:0]    r_rf_pc;
  logic                 r_busy;
  logic                 r_done;

  logic [4:0]           w_count;
  logic [DATA_W-1:0]    w_span;
  logic [DATA_W-1:0]    w_start_addr;
  logic [DATA_W-1:0]    w_final_base;
  logic [NREGS-1:0]     w_mask_rest;
  logic [RADDR_W-1:0]   w_first_reg;
  logic                 w_first_valid;
  logic [RADDR_W-1:0]   w_next_reg;
  logic                 w_next_valid;
  logic                 w_advance;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_count = w_count + 5'(i_reg_list[i]);
    end
  end

  // Both directions place the lowest register at the lowest address.
  assign w_span       = DATA_W'(w_count) * DATA_W'(WORD_BYTES);
  assign w_start_addr = i_up ? i_base_addr : i_base_addr - w_span;
  assign w_final_base = i_up ? i_base_addr + w_span : i_base_addr - w_span;
  assign w_mask_rest  = r_mask & (r_mask - NREGS'(1));

  lowest_set_bit16 u_first_lsb (
    .i_mask  (i_reg_list),
    .o_index (w_first_reg),
    .o_valid (w_first_valid)
  );

  lowest_set_bit16 u_next_lsb (
    .i_mask  (w_mask_rest),
    .o_index (w_next_reg),
    .o_valid (w_next_valid)
  );

  assign w_advance = ((r_state == S_XFER) && i_mem_done && !r_is_load) || (r_state == S_WRITE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_mask         <= '0;
      r_cur_reg      <= '0;
      r_cur_addr     <= '0;
      r_final_base   <= '0;
      r_is_load      <= 1'b0;
      r_wb           <= 1'b0;
      r_base_reg     <= '0;
      r_base_in_list <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_rf_enable    <= 1'b0;
      r_rf_c         <= '0;
      r_rf_pc        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_rf_enable <= 1'b0;
      r_rf_c      <= '0;
      r_rf_pc     <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mask         <= i_reg_list;
            r_cur_reg      <= w_first_reg;
            r_cur_addr     <= w_start_addr;
            r_final_base   <= w_final_base;
            r_is_load      <= i_is_load;
            r_wb           <= i_wb;
            r_base_reg     <= i_base_reg;
            r_base_in_list <= i_reg_list[i_base_reg];
            r_busy         <= 1'b1;
            if (w_first_valid) begin
              r_state   <= S_XFER;
              r_mem_req <= 1'b1;
              r_mem_we  <= !i_is_load;
            end else begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        S_XFER, S_WRITE: begin
          if (w_advance) begin
            r_mask     <= w_mask_rest;
            r_cur_reg  <= w_next_reg;
            r_cur_addr <= r_cur_addr + DATA_W'(WORD_BYTES);
            if (w_next_valid) begin
              r_state   <= S_XFER;
              r_mem_req <= 1'b1;
              r_mem_we  <= !r_is_load;
            end else begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              // A loaded base register keeps the loaded value instead of the writeback.
              if (r_wb && !(r_is_load && r_base_in_list)) begin
                r_state     <= S_WBACK;
                r_rf_enable <= 1'b1;
                r_rf_c      <= r_base_reg;
                r_rf_pc     <= r_final_base;
              end else begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end
            end
          end else if ((r_state == S_XFER) && i_mem_done) begin
            r_state     <= S_WRITE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rf_enable <= 1'b1;
            r_rf_c      <= r_cur_reg;
            r_rf_pc     <= i_mem_rdata;
          end
        end
        S_WBACK: begin
          r_state <= S_FINISH;
          r_done  <= 1'b1;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rf_a      = r_mem_req ? r_cur_reg : '0;
  assign o_mem_addr  = r_mem_req ? r_cur_addr : '0;
  assign o_mem_wdata = (r_mem_req && r_mem_we) ? i_rf_pa : '0;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_rf_enable = r_rf_enable;
  assign o_rf_c      = r_rf_c;
  assign o_rf_pc     = r_rf_pc;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
- Multi-cycle controller that sequences the 16x32 register file and the memory interface for ARM block data transfers (LDM/STM).
- Walks a 16-bit register list from lowest to highest register. For each set bit it issues one memory word access.
- Drives the register file read port (store) or write port (load), then optionally writes the updated base back.
- Sits between instruction control and the register file/memory; owns the register file write port while BUSY.

Parameters:
- DATA_W, 32, data/address width
- NREGS, 16, register count (list width)
- RADDR_W, 4, register address width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request, sampled only in IDLE
- IS_LOAD  in  1  1=LDM (memory->regs), 0=STM
- UP  in  1  1=increment from base, 0=decrement below base
- WB  in  1  write final base back to BASE_REG
- REG_LIST  in  16  register list, bit i = Ri
- BASE_REG  in  4  base register number
- BASE_ADDR  in  32  base register value
- RF_A  out  4  register file read-port select (store source)
- RF_PA  in  32  register file read data for RF_A
- RF_C  out  4  register file write select
- RF_PC  out  32  register file write data
- RF_ENABLE  out  1  register file write enable
- MEM_REQ  out  1  memory request, held until MEM_DONE
- MEM_WE  out  1  1=write (store)
- MEM_ADDR  out  32  word address
- MEM_WDATA  out  32  store data (=RF_PA)
- MEM_RDATA  in  32  load data, valid with MEM_DONE
- MEM_DONE  in  1  access complete
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs 0. Mask, address and count registers cleared. Takes effect immediately, including mid-transfer. An aborted transfer gets no DONE pulse and no writeback.
- START in IDLE latches REG_LIST into mask, latches IS_LOAD/UP/WB/BASE_REG, and computes N=popcount(REG_LIST).
  - Start address: UP → BASE_ADDR; else BASE_ADDR-4N.
  - Final base: BASE_ADDR ± 4N.
  - START while BUSY is ignored.
- Lowest-numbered register always goes to the lowest address.
- States:
  - IDLE: START and mask≠0 → XFER; START and list=0 → FINISH (no access, no writeback).
  - XFER: MEM_REQ=1, MEM_WE=!IS_LOAD, MEM_ADDR=cur_addr, RF_A=cur_reg=lowest set bit of mask.
    - Wait while MEM_DONE=0; outputs are stable while waiting.
    - MEM_DONE with load → capture MEM_RDATA, go to WRITE.
    - MEM_DONE with store → clear bit, cur_addr+=4, go to next.
  - WRITE: RF_ENABLE=1, RF_C=cur_reg, RF_PC=captured data for one cycle. Then clear bit, cur_addr+=4, go to next.
  - next: mask nonzero → XFER; else if WB and not (IS_LOAD and BASE_REG in list) → WBACK; else FINISH.
  - WBACK: RF_ENABLE=1, RF_C=BASE_REG, RF_PC=final base, one cycle → FINISH.
  - FINISH: DONE=1 one cycle → IDLE.
- Timing with zero-wait memory, START at cycle t:
  - Store: XFER at t+1..t+N, WBACK at t+N+1, DONE at t+N+2 (t+N+1 without WB).
  - Load: 2 cycles per register.
- MEM_DONE is accepted on the first cycle of MEM_REQ. MEM_DONE outside XFER is ignored.
- Addresses are modulo 2^32: wrap-around is silent, no fault.
- RF_ENABLE is never high outside WRITE/WBACK, and never high for two registers in the same cycle.
- Store with base in list stores the original base value; writeback happens after all stores.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE, S_XFER, S_WRITE, S_WBACK, S_FINISH
  - WORD_BYTES=4
  - NREGS, RADDR_W
- Sub-module lowest_set_bit16 (combinational priority encoder: 16-bit mask → 4-bit index + valid). It drives both cur_reg and the empty test.
- Popcount is done inline.

Test Plan:
- STM, REG_LIST=16'h000B, BASE_ADDR=32'h100, UP=1, WB=1, BASE_REG=13, zero-wait memory → writes R0,R1,R3 to 0x100,0x104,0x108. Then RF_C=13 with RF_PC=0x10C. DONE at t+5.
- LDM, REG_LIST=16'h8001, BASE_ADDR=32'h200, UP=0, WB=0, MEM_RDATA=A5A5A5A5 then 5A5A5A5A → reads 0x1F8, 0x1FC. R0←A5A5A5A5, R15←5A5A5A5A. No writeback. DONE at t+5.
- MEM_DONE delayed 3 cycles per access → MEM_REQ, MEM_ADDR and RF_A are stable throughout. BUSY stays high. DONE arrives 3 cycles later per access.
- REG_LIST=0, WB=1 → no MEM_REQ, no RF_ENABLE. DONE at t+1.
- LDM with BASE_REG=2 in list, WB=1 → R2 receives loaded data. No WBACK cycle.
- RESET asserted during second XFER → outputs 0 asynchronously, no DONE. A new START after reset runs a full sequence correctly. A START pulse while BUSY is ignored.
